// File: rtl/fifo_sync_thresh.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty thresholds and sticky error flags.
// Latency: a write is visible one edge later; FWFT=0 presents read data one edge after the pop, FWFT=1 shows the head combinationally.
// Backpressure: writes are dropped while full and reads while empty; each dropped request sets a sticky error flag.
module fifo_sync_thresh #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cs,
   input  logic                                wr_en,
   input  logic                                rd_en,
   input  logic                                flush,
   input  logic                                clr_err,
   input  logic [DATA_WIDTH-1:0]               data_in,
   output logic [DATA_WIDTH-1:0]               data_out,
   output logic                                rd_valid,
   output logic                                empty,
   output logic                                full,
   output logic                                almost_empty,
   output logic                                almost_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
   output logic                                overflow,
   output logic                                underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  fl;
   logic                  wa;
   logic                  ra;
   logic                  ovf_set;
   logic                  udf_set;
   logic                  err_clr;

   // Flush takes priority over both requests; full/empty checks use the
   // current count, so a read cannot make room for a same-cycle write.
   assign fl      = cs & flush;
   assign wa      = cs & wr_en & ~full  & ~fl;
   assign ra      = cs & rd_en & ~empty & ~fl;
   assign ovf_set = cs & wr_en & full  & ~fl;
   assign udf_set = cs & rd_en & empty & ~fl;
   assign err_clr = cs & clr_err;

   assign empty        = (count == '0);
   assign full         = (count == CW'(FIFO_DEPTH));
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   // Storage is left unreset so contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (wa) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers and occupancy; flush returns everything to the empty state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (fl) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wa) begin
            wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         end
         if (ra) begin
            rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({wa, ra})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (udf_set) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : mem[rd_ptr];
         assign rd_valid = ~empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] data_q;
         logic                  valid_q;

         // Registered read port: capture the popped word, pulse valid for one cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               if (ra) begin
                  data_q <= mem[rd_ptr];
               end
               valid_q <= ra;
            end
         end

         assign data_out = data_q;
         assign rd_valid = valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync_thresh.sv
module tb_fifo_sync_thresh;
   localparam int DW = 32;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cs, wr_en, rd_en, flush, clr_err;
   logic [DW-1:0] data_in;

   logic [DW-1:0] dout0, dout1;
   logic          rv0, rv1, e0, e1, f0, f1, ae0, ae1, af0, af1, ov0, ov1, un0, un1;
   logic [3:0]    cnt0, cnt1;

   fifo_sync_thresh #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_reg (
      .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .clr_err(clr_err), .data_in(data_in), .data_out(dout0), .rd_valid(rv0), .empty(e0),
      .full(f0), .almost_empty(ae0), .almost_full(af0), .count(cnt0), .overflow(ov0),
      .underflow(un0));

   fifo_sync_thresh #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .clr_err(clr_err), .data_in(data_in), .data_out(dout1), .rd_valid(rv1), .empty(e1),
      .full(f1), .almost_empty(ae1), .almost_full(af1), .count(cnt1), .overflow(ov1),
      .underflow(un1));

   always #5 clk = ~clk;

   // Reference model: a queue of stored words plus the observable registered state.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   bit            m_rv, m_ov, m_un;
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_rv = 0; m_ov = 0; m_un = 0;
   endtask

   task automatic model_step();
      bit fl, fullm, emptym, wacc, racc;
      fl     = cs && flush;
      fullm  = (q.size() == D);
      emptym = (q.size() == 0);
      wacc   = cs && wr_en && !fullm && !fl;
      racc   = cs && rd_en && !emptym && !fl;
      if (cs && clr_err) begin m_ov = 0; m_un = 0; end
      if (cs && wr_en && fullm && !fl) m_ov = 1;
      if (cs && rd_en && emptym && !fl) m_un = 1;
      m_rv = racc;
      if (fl) q.delete();
      else begin
         if (racc) m_dout = q.pop_front();
         if (wacc) q.push_back(data_in);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ".count0"}, 32'(cnt0), 32'(n));
      check({tag, ".count1"}, 32'(cnt1), 32'(n));
      check({tag, ".empty"},  {30'd0, e0, e1}, {30'd0, n == 0, n == 0});
      check({tag, ".full"},   {30'd0, f0, f1}, {30'd0, n == D, n == D});
      check({tag, ".aempty"}, {30'd0, ae0, ae1}, {30'd0, n <= 2, n <= 2});
      check({tag, ".afull"},  {30'd0, af0, af1}, {30'd0, n >= 6, n >= 6});
      check({tag, ".ovf"},    {30'd0, ov0, ov1}, {30'd0, m_ov, m_ov});
      check({tag, ".udf"},    {30'd0, un0, un1}, {30'd0, m_un, m_un});
      check({tag, ".dout0"},  dout0, m_dout);
      check({tag, ".rv0"},    32'(rv0), 32'(m_rv));
      check({tag, ".dout1"},  dout1, (n != 0) ? q[0] : 32'd0);
      check({tag, ".rv1"},    32'(rv1), 32'(n != 0));
   endtask

   task automatic drive(input bit c, input bit w, input bit r, input bit f, input bit ce,
                        input logic [DW-1:0] d);
      cs = c; wr_en = w; rd_en = r; flush = f; clr_err = ce; data_in = d;
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      #1;
      model_step();
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, '0);
      model_reset();
      #12;
      check("rst.count", 32'(cnt0), 32'd0);
      check("rst.flags", {26'd0, e0, f0, ae0, af0, ov0, un0}, {26'd0, 6'b101000});
      check("rst.dout_rv", {dout0[30:0], rv0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Registered read ordering and underflow on the extra read.
      drive(1, 1, 0, 0, 0, 32'd1);   cyc("w1");
      drive(1, 1, 0, 0, 0, 32'd10);  cyc("w10");
      drive(1, 1, 0, 0, 0, 32'd100); cyc("w100");
      drive(1, 0, 1, 0, 0, '0);
      cyc("r1");  check("seq.r1",  {dout0[30:0], rv0}, {31'd1, 1'b1});
      cyc("r2");  check("seq.r2",  {dout0[30:0], rv0}, {31'd10, 1'b1});
      cyc("r3");  check("seq.r3",  {dout0[30:0], rv0}, {31'd100, 1'b1});
      cyc("r4");  check("seq.r4",  {dout0[29:0], rv0, un0}, {30'd100, 1'b0, 1'b1});
      drive(1, 0, 0, 0, 1, '0); cyc("clr1");

      // Fill with powers of two, overflow on the ninth write, drain in order.
      for (int i = 0; i <= 8; i++) begin
         drive(1, 1, 0, 0, 0, 32'(1) << i);
         cyc("pow_w");
         if (i == 7) check("pow.full8", {27'd0, f0, cnt0}, {27'd0, 1'b1, 4'd8});
      end
      check("pow.ovf", 32'(ov0), 32'd1);
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 1, 0, 0, '0);
         cyc("pow_r");
         check("pow.data", dout0, 32'(1) << i);
      end
      drive(1, 0, 0, 0, 1, '0); cyc("clr2");

      // Simultaneous read/write at steady occupancy across pointer wrap, then at full.
      for (int i = 0; i < 5; i++) begin drive(1, 1, 0, 0, 0, $urandom); cyc("sim_fill"); end
      for (int i = 0; i < 10; i++) begin drive(1, 1, 1, 0, 0, $urandom); cyc("sim_rw"); end
      check("sim.count5", 32'(cnt0), 32'd5);
      for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 0, 0, $urandom); cyc("sim_fill8"); end
      drive(1, 1, 1, 0, 0, 32'hdead_beef); cyc("sim_full_rw");
      check("sim.count7_ovf", {27'd0, ov0, cnt0}, {27'd0, 1'b1, 4'd7});
      drive(1, 0, 0, 1, 1, '0); cyc("flush1");

      // Threshold sweep 0..8..0 (flags checked every cycle by check_all).
      for (int i = 0; i < 8; i++) begin drive(1, 1, 0, 0, 0, $urandom); cyc("thr_up"); end
      for (int i = 0; i < 8; i++) begin drive(1, 0, 1, 0, 0, '0); cyc("thr_dn"); end

      // First-word-fall-through head visibility.
      drive(1, 1, 0, 0, 0, 32'd7); cyc("fw_w7");
      drive(1, 0, 0, 0, 0, '0);    cyc("fw_idle");
      check("fw.head", {dout1[30:0], rv1}, {31'd7, 1'b1});
      drive(1, 0, 1, 0, 0, '0);    cyc("fw_r");
      check("fw.empty", {dout1[30:0], e1}, {31'd0, 1'b1});

      // Flush overrides a write; clr_err clears overflow.
      for (int i = 0; i < 4; i++) begin drive(1, 1, 0, 0, 0, $urandom); cyc("fl_fill"); end
      drive(1, 1, 0, 1, 0, 32'h5555_aaaa); cyc("fl_flush");
      check("fl.count0", {27'd0, e0, cnt0}, {27'd0, 1'b1, 4'd0});
      for (int i = 0; i < 9; i++) begin drive(1, 1, 0, 0, 0, $urandom); cyc("fl_ovf"); end
      drive(1, 0, 0, 0, 1, '0); cyc("fl_clr");
      check("fl.ovf_clr", 32'(ov0), 32'd0);

      // Chip select low masks every request.
      drive(0, 1, 1, 1, 1, $urandom); cyc("cs_low");

      // Reset asserted mid-operation.
      drive(1, 1, 0, 0, 0, 32'h1234); cyc("mr_w");
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check("mr.async", {26'd0, e0, f0, cnt0}, {26'd0, 1'b1, 1'b0, 4'd0});
      check("mr.dout", dout0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 1, 0, 0, '0); cyc("mr_rd_empty");

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 8) != 0, ($urandom % 2) == 0, ($urandom % 2) == 0,
               ($urandom % 32) == 0, ($urandom % 16) == 0, $urandom);
         cyc("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_sync_thresh.md
FIFO_SYNC_THRESH -- requirements
Module: fifo_sync_thresh

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count; power of 2, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default 6, almost_full threshold; range 1..FIFO_DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold; range 0..FIFO_DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port cs, input, 1, chip select; gates wr_en, rd_en, flush and clr_err.
REQ-009 SHALL have ports wr_en and rd_en, input, 1 each, write and read requests.
REQ-010 SHALL have port flush, input, 1, synchronous empty-out.
REQ-011 SHALL have port clr_err, input, 1, clears the sticky error flags.
REQ-012 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-013 SHALL have port data_out, output, DATA_WIDTH, read data.
REQ-014 SHALL have port rd_valid, output, 1, data_out carries a newly popped word (FWFT=0) or a valid head (FWFT=1).
REQ-015 SHALL have ports empty, full, almost_empty and almost_full, output, 1 each, status flags.
REQ-016 SHALL have port count, output, $clog2(FIFO_DEPTH+1), current occupancy.
REQ-017 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-018 SHALL accept a write (wa) iff cs & wr_en & !full, storing data_in at wr_ptr.
REQ-019 SHALL accept a read (ra) iff cs & rd_en & !empty, popping the entry at rd_ptr.
REQ-020 SHALL wrap both pointers from FIFO_DEPTH-1 to 0.
REQ-021 SHALL update count each cycle: +1 on wa only, -1 on ra only, unchanged on both or neither; never exceeds FIFO_DEPTH and never goes below 0.
REQ-022 SHALL, when full, reject a simultaneous write even if a read is accepted in the same cycle.
REQ-023 SHALL, when empty, reject a simultaneous read even if a write is accepted in the same cycle.
REQ-024 SHALL derive all status flags from the count register, valid in the same cycle as count: empty = (count==0), full = (count==FIFO_DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-025 SHALL, with FWFT=0, load data_out with the popped word on the edge that accepts ra and hold it otherwise; rd_valid is high for exactly the cycle after each ra.
REQ-026 SHALL, with FWFT=1, drive data_out = mem[rd_ptr] and rd_valid = !empty combinationally; data_out = 0 when empty; ra advances to the next entry.
REQ-027 SHALL set overflow on cs & wr_en & full, and set underflow on cs & rd_en & empty; both stay set until cleared.
REQ-028 SHALL clear both error flags on cs & clr_err; a set condition in the same cycle wins.
REQ-029 SHALL, on cs & flush, zero rd_ptr, wr_ptr and count next edge, ignore wr_en/rd_en that cycle, leave data_out and error flags unchanged, and drive rd_valid low next cycle.
REQ-030 SHALL not clear memory contents on flush or reset.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force wr_ptr=0, rd_ptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0).
REQ-032 SHALL abandon any in-flight access when reset asserts mid-operation; the first access after release sees an empty FIFO.

Verification
REQ-033 SHALL pass: after reset, write 1, 10, 100, then 4 reads with FWFT=0 -> data_out 1, 10, 100 on successive rd_valid pulses; 4th read gives underflow=1, rd_valid=0, data_out held at 100.
REQ-034 SHALL pass: write 2**i for i=0..8 with no reads -> full=1 and count=8 after the 8th write; 9th write dropped, overflow=1; 8 reads return 1..128 in order.
REQ-035 SHALL pass: fill to count=5, then cs & wr_en & rd_en for 10 cycles -> count stays 5, FIFO order preserved across pointer wrap; with count=8 and simultaneous rd/wr -> count=7, overflow=1.
REQ-036 SHALL pass: with defaults, step count 0..8..0 -> almost_empty high only for count<=2, almost_full high only for count>=6.
REQ-037 SHALL pass: with FWFT=1, write 7 -> data_out=7 and rd_valid=1 the cycle after the write with no read issued; read -> empty=1, data_out=0.
REQ-038 SHALL pass: with count=4, assert flush with wr_en=1 -> count=0, empty=1, no write stored; then clr_err with overflow set -> overflow=0 next cycle.
